// File: rtl/fpu_issue.sv
// -----------------------------------------------------------------------------
// fpu_issue
//   Core-side initiator for the FPU go/valid handshake. It accepts one FP op
//   from decode, holds the operands stable towards the FPU, pulses fpu_go for a
//   single cycle, waits for fpu_valid, and presents the captured result to FP
//   register writeback. Only one op is in flight at a time, and busy stalls the
//   core pipe.
//
//   Parameters
//     MIN_LAT  cycles after the fpu_go pulse during which fpu_valid is ignored
//              (this masks a stale valid left over from a previous op)
//     TIMEOUT  maximum number of WAIT cycles before an abort
//              (only used when FPU_TIMEOUT_EN is defined)
//
//   Optional feature: define FPU_TIMEOUT_EN to add the timeout_err output and
//   the WAIT watchdog. Without it, WAIT waits indefinitely for fpu_valid.
//
//   Ports
//     clk, reset          clock; synchronous active-high reset
//     req_*               decode request (valid/ready, op, mode, a, b, rd)
//     fpu_a/b/control/mode
//                         registered operands and controls to the FPU
//     fpu_go              single-cycle start pulse
//     fpu_valid, fpu_c    FPU result handshake
//     wb_valid/ready      writeback handshake
//     wb_rd, wb_data      writeback destination register and data
//     illegal_op          qualifies wb_valid: op code >= 10, data forced to 0
//     busy                high whenever the issuer is not idle
//     timeout_err         (FPU_TIMEOUT_EN) qualifies wb_valid: FPU timed out
// -----------------------------------------------------------------------------
module fpu_issue #(
    parameter int MIN_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_mode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [3:0]  fpu_control,
    output logic        fpu_mode,
    output logic        fpu_go,
    input  logic        fpu_valid,
    input  logic [31:0] fpu_c,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal_op,
    output logic        busy
`ifdef FPU_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] MIN_LAT_C = 8'(MIN_LAT);
    localparam logic [3:0] NUM_OPS   = 4'd10;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  ctl_q, ctl_d;
    logic        mode_q, mode_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        ill_q, ill_d;

`ifdef FPU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  tcnt_inc;
    logic        tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctl_d   = ctl_q;
        mode_d  = mode_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ill_d   = ill_q;
`ifdef FPU_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        tmo_d    = tmo_q;
        tcnt_inc = (tcnt_q == TIMEOUT_C) ? TIMEOUT_C : tcnt_q + 8'd1;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    ctl_d  = req_op;
                    mode_d = req_mode;
                    rd_d   = req_rd;
                    if (req_op >= NUM_OPS) begin
                        // Unknown op: never start the FPU, answer with 0 at once.
                        state_d = S_DONE;
                        data_d  = 32'd0;
                        ill_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        ill_d   = 1'b0;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = MIN_LAT_C;
                state_d = S_WAIT;
`ifdef FPU_TIMEOUT_EN
                tcnt_d  = 8'd0;
`endif
            end

            S_WAIT: begin
                if (cnt_q != 8'd0) begin
                    // Blanking window: any fpu_valid here belongs to an older op.
                    cnt_d = cnt_q - 8'd1;
                end else if (fpu_valid) begin
                    data_d  = fpu_c;
                    state_d = S_DONE;
                end
`ifdef FPU_TIMEOUT_EN
                // A real result in the same cycle wins over the watchdog.
                if (state_d == S_WAIT) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TIMEOUT_C) begin
                        data_d  = 32'hFFFF_FFFF;
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
`endif
            end

            S_DONE: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                    ill_d   = 1'b0;
`ifdef FPU_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            ctl_q   <= 4'd0;
            mode_q  <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            ill_q   <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            tcnt_q  <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctl_q   <= ctl_d;
            mode_q  <= mode_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
`ifdef FPU_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // All handshake outputs decode directly from the state register.
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fpu_go      = (state_q == S_ISSUE);
    assign wb_valid    = (state_q == S_DONE);
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_control = ctl_q;
    assign fpu_mode    = mode_q;
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign illegal_op  = ill_q;
`ifdef FPU_TIMEOUT_EN
    assign timeout_err = tmo_q;
`endif

endmodule
